// File: rtl/ram_prog_ctrl.sv
// Program-RAM controller: streams loader bytes into a 16x8 RAM, then hands the RAM to the CPU.
// Define RAM_PROG_VERIFY_EN to add an xor-checksum read-back pass (VERIFY) between load and run.
module ram_prog_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic              cpu_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_low_load,
  output logic              mem_low_o_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              prog_busy,
  output logic              prog_done,
  output logic              verify_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              prog_done_q;
  logic              accept;
  logic              load_end;

  assign accept   = (state_q == StLoad) && ld_valid;
  // The top-address exit keeps ptr from wrapping inside a single load.
  assign load_end = accept && (ld_last || (ptr_q == ADDR_W'(DEPTH - 1)));

`ifdef RAM_PROG_VERIFY_EN
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] csum_next;
  logic              verify_err_q;

  assign csum_next = csum_q ^ mem_data_out;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      last_q       <= '0;
      csum_q       <= '0;
      prog_done_q  <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (prog_start) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            csum_q      <= '0;
            prog_done_q <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            csum_q <= csum_q ^ ld_data;
            last_q <= ptr_q;
            if (load_end) begin
              state_q <= StVerify;
              // ptr doubles as the read-back pointer during VERIFY.
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + ADDR_W'(1);
            end
          end
        end
        StVerify: begin
          csum_q <= csum_next;
          if (ptr_q == last_q) begin
            state_q      <= StRun;
            prog_done_q  <= 1'b1;
            verify_err_q <= (csum_next != '0);
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        StRun: begin
          if (prog_start) begin
            state_q      <= StLoad;
            ptr_q        <= '0;
            csum_q       <= '0;
            prog_done_q  <= 1'b0;
            verify_err_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign verify_err = verify_err_q;
`else
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      prog_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (prog_start) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            prog_done_q <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (load_end) begin
              state_q     <= StRun;
              prog_done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (prog_start) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            prog_done_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data is only needed by the read-back pass.
  logic unused_mem_data_out;
  assign unused_mem_data_out = ^mem_data_out;
  assign verify_err          = 1'b0;
`endif

  always_comb begin
    ld_ready     = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_low_load = 1'b1;
    mem_low_o_en = 1'b1;
    unique case (state_q)
      StLoad: begin
        ld_ready     = 1'b1;
        mem_addr     = ptr_q;
        mem_data_in  = ld_data;
        mem_low_load = ~ld_valid;
      end
`ifdef RAM_PROG_VERIFY_EN
      StVerify: begin
        mem_addr     = ptr_q;
        mem_low_o_en = 1'b0;
      end
`endif
      StRun: begin
        mem_addr     = cpu_addr;
        mem_low_o_en = ~cpu_rd;
      end
      default: ;
    endcase
  end

  assign cpu_grant = (state_q == StRun);
  assign prog_busy = (state_q == StLoad) || (state_q == StVerify);
  assign prog_done = prog_done_q;

endmodule

// File: tb/tb_ram_prog_ctrl.sv
// Bench for ram_prog_ctrl: models the 16x8 RAM, streams programs, checks reads via a scoreboard.
module tb_ram_prog_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       prog_start;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_last;
  logic       ld_ready;
  logic [3:0] cpu_addr;
  logic       cpu_rd;
  logic       cpu_grant;
  logic [3:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_low_load;
  logic       mem_low_o_en;
  logic [7:0] mem_data_out;
  logic       prog_busy;
  logic       prog_done;
  logic       verify_err;

  logic [7:0] ram [16];
  logic [7:0] exp_mem [16];
  logic [7:0] sb_q [$];
  logic       ram_init;
  logic       flip_en;
  logic       flip_now;
  int         errors = 0;
  int         checks = 0;

`ifdef RAM_PROG_VERIFY_EN
  localparam int VMul = 1;
`else
  localparam int VMul = 0;
`endif

  always #5 clk = ~clk;

  ram_prog_ctrl dut (
    .clk          (clk),
    .clr          (clr),
    .prog_start   (prog_start),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .cpu_addr     (cpu_addr),
    .cpu_rd       (cpu_rd),
    .cpu_grant    (cpu_grant),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_low_load (mem_low_load),
    .mem_low_o_en (mem_low_o_en),
    .mem_data_out (mem_data_out),
    .prog_busy    (prog_busy),
    .prog_done    (prog_done),
    .verify_err   (verify_err)
  );

  // RAM model: write on the clock edge while low_load is low, combinational read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h80 + 8'(i);
    end else if (!mem_low_load) begin
      ram[mem_addr] <= mem_data_in;
    end
  end

  // Fault injection: corrupt one read-back word (addr 2) while in VERIFY.
  assign flip_now     = flip_en && prog_busy && !ld_ready && (mem_addr == 4'd2);
  assign mem_data_out = ram[mem_addr] ^ {7'b0, flip_now};

  task automatic start_prog();
    prog_start = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
    #1;
    checks++;
    if ({prog_busy, ld_ready, prog_done, cpu_grant, verify_err, mem_low_load, mem_addr} !==
        {5'b11000, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL start_prog: busy/rdy/done/grant/err/low_load/addr got %b%b%b%b%b %b %h want 11000 1 0",
               prog_busy, ld_ready, prog_done, cpu_grant, verify_err, mem_low_load, mem_addr);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic ps, input int a);
    ld_valid   = 1'b1;
    ld_data    = d;
    ld_last    = last;
    prog_start = ps;
    #1;
    checks++;
    if ({mem_addr, mem_low_load, mem_data_in} !== {4'(a), 1'b0, d}) begin
      errors++;
      $display("FAIL write a=%0d: addr/low_load/data got %h %b %h want %h 0 %h",
               a, mem_addr, mem_low_load, mem_data_in, 4'(a), d);
    end
    exp_mem[a] = d;
    @(negedge clk);
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    prog_start = 1'b0;
  endtask

  task automatic gap_cycle(input int a);
    ld_valid = 1'b0;
    #1;
    checks++;
    if ({mem_low_load, ld_ready, mem_addr} !== {2'b11, 4'(a)}) begin
      errors++;
      $display("FAIL gap a=%0d: low_load/ready/addr got %b%b %h want 11 %h",
               a, mem_low_load, ld_ready, mem_addr, 4'(a));
    end
    @(negedge clk);
  endtask

  task automatic wait_run(input int exp_cyc, input logic exp_err);
    int cnt = 0;
    while (!cpu_grant && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    #1;
    checks++;
    if (!(cpu_grant === 1'b1 && cnt == exp_cyc)) begin
      errors++;
      $display("FAIL run_entry: grant=%b after %0d cycles want grant=1 after %0d",
               cpu_grant, cnt, exp_cyc);
    end
    checks++;
    if ({prog_done, prog_busy, verify_err} !== {1'b1, 1'b0, exp_err}) begin
      errors++;
      $display("FAIL run_flags: done/busy/err got %b%b%b want 10%b",
               prog_done, prog_busy, verify_err, exp_err);
    end
  endtask

  task automatic read_all(input string tag);
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      cpu_rd   = 1'b1;
      sb_q.push_back(exp_mem[a]);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if ({mem_low_o_en, mem_data_out} !== {1'b0, exp}) begin
        errors++;
        $display("FAIL %s read a=%0d: o_en/data got %b %h want 0 %h",
                 tag, a, mem_low_o_en, mem_data_out, exp);
      end
      @(negedge clk);
    end
    cpu_rd = 1'b0;
    #1;
    checks++;
    if ({mem_low_o_en, mem_low_load} !== 2'b11) begin
      errors++;
      $display("FAIL %s rd_off: o_en/low_load got %b%b want 11", tag, mem_low_o_en, mem_low_load);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; ram_init = 1'b1; prog_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = 8'h00; cpu_addr = 4'h7; cpu_rd = 1'b1; flip_en = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h80 + 8'(i);
    @(negedge clk);
    clr = 1'b0; ram_init = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({prog_busy, prog_done, verify_err, cpu_grant, ld_ready, mem_low_load, mem_low_o_en,
           mem_addr, mem_data_in} !== {5'b0, 2'b11, 4'h0, 8'h00}) begin
        errors++;
        $display("FAIL reset k=%0d: busy/done/err/grant/rdy/ll/oe %b%b%b%b%b%b%b addr %h din %h want 0000011 0 00",
                 k, prog_busy, prog_done, verify_err, cpu_grant, ld_ready, mem_low_load,
                 mem_low_o_en, mem_addr, mem_data_in);
      end
      @(negedge clk);
    end
    cpu_rd = 1'b0;
  endtask

  task automatic test_full_load();
    start_prog();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0, i);
    wait_run(VMul * 16, 1'b0);
    read_all("full");
  endtask

  task automatic test_early_end();
    // prog_start coincides with the final accept and must be ignored.
    start_prog();
    send_byte(8'hA5, 1'b0, 1'b0, 0);
    send_byte(8'h3C, 1'b1, 1'b1, 1);
    wait_run(VMul * 2, 1'b0);
    read_all("early");
  endtask

  task automatic test_backpressure();
    start_prog();
    gap_cycle(0);
    send_byte(8'h11, 1'b0, 1'b0, 0);
    gap_cycle(1);
    send_byte(8'h22, 1'b0, 1'b0, 1);
    gap_cycle(2);
    gap_cycle(2);
    send_byte(8'h33, 1'b1, 1'b0, 2);
    wait_run(VMul * 3, 1'b0);
    read_all("bp");
  endtask

  task automatic test_reset_mid_load();
    start_prog();
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0, 1'b0, i);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if ({prog_busy, ld_ready, cpu_grant, prog_done, mem_low_load} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_clr: busy/rdy/grant/done/ll got %b%b%b%b%b want 00001",
               prog_busy, ld_ready, cpu_grant, prog_done, mem_low_load);
    end
    start_prog();
    send_byte(8'h77, 1'b1, 1'b0, 0);
    wait_run(VMul * 1, 1'b0);
    read_all("midclr");
  endtask

`ifdef RAM_PROG_VERIFY_EN
  task automatic test_verify();
    for (int f = 1; f >= 0; f--) begin
      flip_en = f[0];
      start_prog();
      for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i * 3), i == 3, 1'b0, i);
      wait_run(4, f[0]);
      flip_en = 1'b0;
    end
    read_all("verify");
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_early_end();
    test_backpressure();
    test_reset_mid_load();
`ifdef RAM_PROG_VERIFY_EN
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
